// File: rtl/face_scan_sequencer.sv
// Steps each cube face through detect, centers, colour-store and colour-check stages,
// with a per-stage done timeout and bounded colour-check retries.
module face_scan_sequencer #(
  parameter int NUM_FACES      = 6,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int MAX_RETRY      = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       Face,
  output logic       ds,
  input  logic       ds_done,
  output logic       gc,
  input  logic       gc_done,
  output logic       cs,
  input  logic       cs_done,
  output logic       cc,
  input  logic       cc_done,
  input  logic       cc_ok,
  output logic [2:0] face_idx,
  output logic [1:0] retry_cnt,
  output logic       busy,
  output logic       algstart,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, DS, DS_W, GC, GC_W, CS, CS_W, CC, CC_W, STOP, HALT, ERR
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tmr;
  logic          face_q;
  logic          face_rise;
  logic          tmo;
  logic          in_wait;
  logic          retry_left;
  logic          last_face;

  assign face_rise  = Face & ~face_q;
  assign tmo        = (tmr == TW'(TIMEOUT_CYCLES - 1));
  assign in_wait    = state inside {DS_W, GC_W, CS_W, CC_W};
  assign retry_left = (int'(retry_cnt) + 1) < MAX_RETRY;
  assign last_face  = (face_idx == 3'(NUM_FACES - 1));

  // Execute low overrides everything; in wait states a done strobe beats the timeout.
  always_comb begin
    state_n = state;
    if (!Execute) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: state_n = DS;
        DS:   state_n = DS_W;
        GC:   state_n = GC_W;
        CS:   state_n = CS_W;
        CC:   state_n = CC_W;
        DS_W: begin
          if (ds_done)  state_n = GC;
          else if (tmo) state_n = ERR;
        end
        GC_W: begin
          if (gc_done)  state_n = CS;
          else if (tmo) state_n = ERR;
        end
        CS_W: begin
          if (cs_done)  state_n = CC;
          else if (tmo) state_n = ERR;
        end
        CC_W: begin
          if (cc_done) begin
            if (cc_ok)           state_n = last_face ? HALT : STOP;
            else if (retry_left) state_n = DS;
            else                 state_n = ERR;
          end else if (tmo) begin
            state_n = ERR;
          end
        end
        STOP: if (face_rise) state_n = DS;
        HALT: state_n = HALT;
        ERR:  state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      face_q    <= 1'b0;
      tmr       <= '0;
      face_idx  <= '0;
      retry_cnt <= '0;
      ds        <= 1'b0;
      gc        <= 1'b0;
      cs        <= 1'b0;
      cc        <= 1'b0;
      busy      <= 1'b0;
      algstart  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state  <= state_n;
      face_q <= Face;
      tmr    <= (in_wait && state_n == state) ? tmr + TW'(1) : '0;
      if (state_n == DS) begin
        if (state == IDLE) begin
          face_idx  <= '0;
          retry_cnt <= '0;
        end else if (state == STOP) begin
          face_idx  <= face_idx + 3'd1;
          retry_cnt <= '0;
        end else if (state == CC_W) begin
          retry_cnt <= retry_cnt + 2'd1;
        end
      end
      ds       <= (state_n == DS);
      gc       <= (state_n == GC);
      cs       <= (state_n == CS);
      cc       <= (state_n == CC);
      busy     <= !(state_n inside {IDLE, HALT, ERR});
      algstart <= (state_n == HALT);
      error    <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_face_scan_sequencer.sv
// Bench for face_scan_sequencer: the bench plays every stage with random latency and
// stray strobes, predicting each cycle's outputs from the face/retry plan it chose.
module tb_face_scan_sequencer;

  localparam int NF = 6;
  localparam int TO = 1023;
  localparam int MR = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Execute, Face;
  logic       ds_done, gc_done, cs_done, cc_done, cc_ok;
  logic       ds, gc, cs, cc, busy, algstart, error;
  logic [2:0] face_idx;
  logic [1:0] retry_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int ds_seen  = 0;
  int cyc      = 0;

  always #5 Clk = ~Clk;

  face_scan_sequencer #(.NUM_FACES(NF), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .Clk(Clk), .Reset(Reset), .Execute(Execute), .Face(Face),
    .ds(ds), .ds_done(ds_done), .gc(gc), .gc_done(gc_done),
    .cs(cs), .cs_done(cs_done), .cc(cc), .cc_done(cc_done), .cc_ok(cc_ok),
    .face_idx(face_idx), .retry_cnt(retry_cnt),
    .busy(busy), .algstart(algstart), .error(error)
  );

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (ds === 1'b1) ds_seen <= ds_seen + 1;
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic clr_done();
    ds_done = 1'b0; gc_done = 1'b0; cs_done = 1'b0; cc_done = 1'b0; cc_ok = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] p, input int f, input int r,
                            input logic b, input logic a, input logic e);
    logic [11:0] obs, exp;
    obs = {ds, gc, cs, cc, face_idx, retry_cnt, busy, algstart, error};
    exp = {p, 3'(f), 2'(r), b, a, e};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [3:0] p, input logic b,
                            input logic a, input logic e);
    logic [6:0] obs, exp;
    obs = {ds, gc, cs, cc, busy, algstart, error};
    exp = {p, b, a, e};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge of a pulse cycle; returns at the negedge of the following state.
  task automatic run_stage(input int s, input int lat, input bit ok, input int f, input int r);
    logic [3:0] me, stray;
    me = 4'(4'b1000 >> s);
    expect_out("stage_pulse", me, f, r, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      expect_out("stage_wait", 4'b0000, f, r, 1'b1, 1'b0, 1'b0);
      stray = 4'($urandom_range(0, 15)) & ~me;
      {ds_done, gc_done, cs_done, cc_done} = stray | ((i == lat) ? me : 4'b0000);
      cc_ok = (i == lat && s == 3) ? ok : 1'($urandom_range(0, 1));
    end
    tick();
    clr_done();
  endtask

  task automatic run_face(input int f, input int nfail, input bit last_ok, input int fixed_lat,
                          input bit hold);
    int r, lat, base, c0;
    r = 0;
    base = ds_seen;
    c0 = cyc;
    for (int a = 0; a <= nfail; a++) begin
      for (int s = 0; s < 4; s++) begin
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
        if (hold && a == nfail && s == 3) Face = 1'b1;
        run_stage(s, lat, (a == nfail) && last_ok, f, r);
      end
      if (a < nfail) r++;
    end
    chk("ds_per_face", ds_seen - base, nfail + 1);
    if (fixed_lat == 1 && nfail == 0 && last_ok) chk("face_cycles", cyc - c0, 8);
  endtask

  // Starts from IDLE; ends at HALT after the last face, else in STOP of last_face.
  task automatic run_scan(input int last_face, input bit rnd, input int retry_face,
                          input int hold_face);
    int nf, d;
    Execute = 1'b1;
    tick();
    for (int f = 0; f <= last_face; f++) begin
      if (f == retry_face) nf = 2;
      else if (rnd)        nf = $urandom_range(0, MR - 1);
      else                 nf = 0;
      run_face(f, nf, 1'b1, rnd ? 0 : 1, f == hold_face);
      if (f == NF - 1) begin
        expect_out("halt", 4'b0000, f, nf, 1'b0, 1'b1, 1'b0);
      end else begin
        expect_out("stop", 4'b0000, f, nf, 1'b1, 1'b0, 1'b0);
        if (f < last_face) begin
          if (f == hold_face) begin
            for (int i = 0; i < 3; i++) begin
              tick();
              expect_out("stop_face_held", 4'b0000, f, nf, 1'b1, 1'b0, 1'b0);
            end
            Face = 1'b0;
            tick();
            expect_out("stop_face_low", 4'b0000, f, nf, 1'b1, 1'b0, 1'b0);
          end
          d = rnd ? $urandom_range(0, 3) : 0;
          for (int i = 0; i < d; i++) begin
            tick();
            expect_out("stop_idle", 4'b0000, f, nf, 1'b1, 1'b0, 1'b0);
          end
          Face = 1'b1;
          tick();
          Face = 1'b0;
        end
      end
    end
  endtask

  task automatic halt_exit();
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_ctl("halt_hold", 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    Execute = 1'b0;
    tick();
    expect_ctl("halt_exit", 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    Execute = 1'b0;
    Face = 1'b0;
    clr_done();
    #2 Reset = 1'b1;
    #1 expect_out("reset", 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;

    // idle ignores stray Face and done strobes
    for (int i = 0; i < 4; i++) begin
      Face = 1'($urandom_range(0, 1));
      {ds_done, gc_done, cs_done, cc_done} = 4'($urandom_range(0, 15));
      tick();
      expect_out("idle_stray", 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    Face = 1'b0;
    clr_done();
    tick();

    // nominal scan, one-cycle latencies
    base = ds_seen;
    run_scan(NF - 1, 1'b0, -1, -1);
    chk("nominal_ds_total", ds_seen - base, NF);
    halt_exit();

    // two retries on face 2, Face held high into STOP of face 3
    base = ds_seen;
    run_scan(NF - 1, 1'b0, 2, 3);
    chk("retry_ds_total", ds_seen - base, NF + 2);
    halt_exit();

    // randomized scans
    for (int k = 0; k < 3; k++) begin
      run_scan(NF - 1, 1'b1, -1, -1);
      halt_exit();
    end

    // retry exhaustion on face 0
    Execute = 1'b1;
    tick();
    run_face(0, MR - 1, 1'b0, 0, 1'b0);
    expect_ctl("exhaust_err", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    expect_ctl("exhaust_err_hold", 4'b0000, 1'b0, 1'b0, 1'b1);
    Execute = 1'b0;
    tick();
    expect_ctl("exhaust_exit", 4'b0000, 1'b0, 1'b0, 1'b0);

    // timeout in GC_W with only stray strobes
    Execute = 1'b1;
    tick();
    run_stage(0, 1, 1'b1, 0, 0);
    expect_out("to_gc", 4'b0100, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= TO; j++) begin
      tick();
      expect_out("to_wait", 4'b0000, 0, 0, 1'b1, 1'b0, 1'b0);
      {ds_done, gc_done, cs_done, cc_done} = 4'($urandom_range(0, 15)) & 4'b1011;
      cc_ok = 1'($urandom_range(0, 1));
    end
    tick();
    clr_done();
    expect_ctl("to_err", 4'b0000, 1'b0, 1'b0, 1'b1);
    Execute = 1'b0;
    tick();
    expect_ctl("to_exit", 4'b0000, 1'b0, 1'b0, 1'b0);

    // gc_done on the timeout cycle wins
    Execute = 1'b1;
    tick();
    run_stage(0, 1, 1'b1, 0, 0);
    run_stage(1, TO, 1'b1, 0, 0);
    expect_out("to_done_wins", 4'b0010, 0, 0, 1'b1, 1'b0, 1'b0);
    Execute = 1'b0;
    tick();
    expect_ctl("to_done_exit", 4'b0000, 1'b0, 1'b0, 1'b0);

    // abort in the same cycle as cs_done
    Execute = 1'b1;
    tick();
    run_stage(0, 1, 1'b1, 0, 0);
    run_stage(1, 2, 1'b1, 0, 0);
    expect_out("abort_cs", 4'b0010, 0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    cs_done = 1'b1;
    Execute = 1'b0;
    tick();
    clr_done();
    expect_ctl("abort_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("abort_stay", 4'b0000, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of face 4
    run_scan(3, 1'b1, -1, -1);
    Face = 1'b1;
    tick();
    Face = 1'b0;
    expect_out("f4_ds", 4'b1000, 4, 0, 1'b1, 1'b0, 1'b0);
    tick();
    #2 Reset = 1'b1;
    #1 expect_out("async_reset", 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    Execute = 1'b0;
    tick();
    expect_out("post_reset", 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/face_scan_sequencer.md
# face_scan_sequencer

Handshaked sequencer for the cube-face colour capture datapath in the DE2 CCD camera path. It scans NUM_FACES faces. For each face it runs four stages in order: detect-start, get-centers, colour-store and colour-check. Each stage gets a one-cycle start pulse, then the block waits for that stage's done strobe. Failed colour checks are retried, stalled stages are caught by a timeout, and once every face passes the block raises algstart for the solver.

## Interface
- NUM_FACES, 6, faces per scan session (2..8)
- TIMEOUT_CYCLES, 1023, maximum cycles to wait for any stage done strobe
- MAX_RETRY, 3, colour-check failures allowed per face before error
- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- Execute  in  1  session enable (level); low aborts to idle
- Face  in  1  operator "next face ready"; only its rising edge is used
- ds  out  1  detect-start pulse
- ds_done  in  1  detect stage complete strobe
- gc  out  1  get-centers pulse
- gc_done  in  1  centers stage complete strobe
- cs  out  1  colour-store pulse
- cs_done  in  1  colour-store complete strobe
- cc  out  1  colour-check pulse
- cc_done  in  1  colour-check complete strobe
- cc_ok  in  1  check result, valid only when cc_done=1
- face_idx  out  3  current face, 0..NUM_FACES-1
- retry_cnt  out  2  failed checks on the current face
- busy  out  1  high in every state except IDLE, HALT and ERR
- algstart  out  1  scan complete, level while in HALT
- error  out  1  level while in ERR

## Operation
- States: IDLE, DS, DS_W, GC, GC_W, CS, CS_W, CC, CC_W, STOP, HALT, ERR.
- Moore outputs:
  - ds, gc, cs and cc are high only in DS, GC, CS and CC respectively, so each is exactly one cycle per visit.
- IDLE:
  - Execute=1 goes to DS, with face_idx=0 and retry_cnt=0.
- Pulse states:
  - DS goes to DS_W, GC to GC_W, CS to CS_W, CC to CC_W, unconditionally.
  - Done inputs are ignored in pulse states.
- Wait states:
  - On the matching done strobe: DS_W goes to GC, GC_W to CS, CS_W to CC.
  - CC_W with cc_done=1 and cc_ok=1: if face_idx=NUM_FACES-1, go to HALT; otherwise go to STOP.
  - CC_W with cc_done=1 and cc_ok=0: if retry_cnt+1 < MAX_RETRY, increment retry_cnt and go to DS (same face); otherwise go to ERR.
  - Done strobes from a stage other than the one being waited on are ignored.
- STOP:
  - A Face rising edge (Face=1 now, 0 the previous cycle) goes to DS, increments face_idx and clears retry_cnt.
  - Face edges that occur outside STOP are discarded and do not carry into STOP.
- HALT:
  - Holds algstart=1 until Execute=0, then goes to IDLE.
- ERR:
  - Holds error=1 until Execute=0, then goes to IDLE.
- Abort: Execute=0 in any state goes to IDLE on the next edge. This takes priority over every other transition, including done strobes in the same cycle.
- Timeout:
  - The timeout counter clears on entry to each *_W state and increments every cycle spent in it.
  - If the counter reaches TIMEOUT_CYCLES with no done strobe, go to ERR.
  - A done strobe in the same cycle the counter reaches TIMEOUT_CYCLES counts as done (done wins).
- Width rules:
  - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - face_idx never wraps past NUM_FACES-1; retry_cnt saturates at MAX_RETRY-1.
- Reset (asynchronous, at any time including mid-scan):
  - State goes to IDLE immediately.
  - All outputs go to 0, face_idx=0, retry_cnt=0, timeout counter 0, Face edge register 0.

## Timing
- Execute rises at edge N: DS (ds=1) during cycle N+1.
- With every done strobe returned one cycle after its pulse, one face takes 8 cycles from DS to STOP or HALT.
- A done strobe seen at edge k moves the FSM to the next pulse state, so that pulse is asserted in cycle k+1.
- A Face edge sampled in STOP at edge k: DS in cycle k+1, with face_idx already incremented.
- Retry: the DS pulse follows the failing cc_done by exactly one cycle.
- Abort, HALT exit and ERR exit all take one cycle to reach IDLE.

## Test plan
- Nominal scan:
  - Stimulus: Execute=1; each done returned one cycle after its pulse with cc_ok=1; a Face pulse after each STOP.
  - Required response: 6 ds/gc/cs/cc pulses each; face_idx steps 0 through 5; algstart=1 eight cycles after the last Face edge; Execute=0 then returns to IDLE in 1 cycle.
- Retry path:
  - Stimulus: on face 2, cc_ok=0 twice, then 1.
  - Required response: retry_cnt goes 1 then 2, then clears when face 3 starts; ds is pulsed 3 times for face 2; no error.
- Retry exhaustion:
  - Stimulus: cc_ok=0 three times on face 0.
  - Required response: ERR and error=1 after the third cc_done; busy=0; error clears one cycle after Execute=0.
- Timeout:
  - Stimulus: gc_done is never asserted.
  - Required response: ERR exactly TIMEOUT_CYCLES cycles after entering GC_W.
  - Stimulus: gc_done asserted on the cycle the counter reaches TIMEOUT_CYCLES.
  - Required response: moves to CS, no error.
- Abort and stray inputs:
  - Stimulus: Execute=0 in the same cycle as cs_done.
  - Required response: goes to IDLE, not CC.
  - Stimulus: Face held high through CC_W into STOP.
  - Required response: no advance until Face falls and rises again.
- Reset:
  - Stimulus: Reset asserted asynchronously in the middle of face 4.
  - Required response: all outputs 0 and face_idx=0 immediately, before the next edge.
